// File: rtl/icb_pkg.sv
// Shared ICB widths and FSM state encoding for the block master.
package icb_pkg;

   localparam int ICB_ADDR_W = 32;
   localparam int ICB_DATA_W = 32;
   localparam int ICB_MASK_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } blk_state_e;

endpackage

// File: rtl/icb_block_master_if.sv
// Bundle of block-request, data-stream and ICB master signals around icb_block_master.
interface icb_block_master_if #(
   parameter int len_width = 16
);
   import icb_pkg::*;

   logic [ICB_ADDR_W-1:0] blk_req_addr;
   logic [len_width-1:0]  blk_req_len;
   logic                  blk_req_read;
   logic                  blk_req_valid;
   logic                  blk_req_ready;
   logic                  blk_done;
   logic                  blk_err;

   logic [ICB_DATA_W-1:0] s_wdata;
   logic                  s_wdata_valid;
   logic                  s_wdata_ready;
   logic [ICB_DATA_W-1:0] m_rdata;
   logic                  m_rdata_valid;
   logic                  m_rdata_ready;

   logic [ICB_ADDR_W-1:0] m_icb_cmd_addr;
   logic                  m_icb_cmd_read;
   logic [ICB_DATA_W-1:0] m_icb_cmd_wdata;
   logic [ICB_MASK_W-1:0] m_icb_cmd_wmask;
   logic                  m_icb_cmd_valid;
   logic                  m_icb_cmd_ready;
   logic [ICB_DATA_W-1:0] m_icb_rsp_rdata;
   logic                  m_icb_rsp_err;
   logic                  m_icb_rsp_valid;
   logic                  m_icb_rsp_ready;

   modport master (
      input  blk_req_addr, blk_req_len, blk_req_read, blk_req_valid,
      output blk_req_ready, blk_done, blk_err,
      input  s_wdata, s_wdata_valid,
      output s_wdata_ready,
      output m_rdata, m_rdata_valid,
      input  m_rdata_ready,
      output m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask, m_icb_cmd_valid,
      input  m_icb_cmd_ready,
      input  m_icb_rsp_rdata, m_icb_rsp_err, m_icb_rsp_valid,
      output m_icb_rsp_ready
   );

   modport slave (
      output blk_req_addr, blk_req_len, blk_req_read, blk_req_valid,
      input  blk_req_ready, blk_done, blk_err,
      output s_wdata, s_wdata_valid,
      input  s_wdata_ready,
      input  m_rdata, m_rdata_valid,
      output m_rdata_ready,
      input  m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask, m_icb_cmd_valid,
      output m_icb_cmd_ready,
      output m_icb_rsp_rdata, m_icb_rsp_err, m_icb_rsp_valid,
      input  m_icb_rsp_ready
   );

endinterface

// File: rtl/icb_outstanding_cnt.sv
// Up/down counter of commands accepted but not yet answered, with an "at limit" flag.
module icb_outstanding_cnt #(
   parameter int max_cnt = 4,
   localparam int CW = $clog2(max_cnt + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_at_limit
);

   localparam logic [CW-1:0] LIMIT = CW'(max_cnt);
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] ZERO  = CW'(0);

   logic [CW-1:0] r_cnt;

   // Simultaneous inc/dec cancels, which covers slaves answering in the issue cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= ZERO;
      end else if (i_inc && !i_dec) begin
         r_cnt <= r_cnt + ONE;
      end else if (i_dec && !i_inc && (r_cnt != ZERO)) begin
         r_cnt <= r_cnt - ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_at_limit = (r_cnt >= LIMIT);

endmodule

// File: rtl/icb_block_master.sv
// ICB master engine: turns one block request into a burst of aligned word commands and
// tracks responses until the whole block is answered.
module icb_block_master
   import icb_pkg::*;
#(
   parameter int max_outstanding = 4,
   parameter int len_width       = 16
) (
   input  logic                m_icb_aclk,
   input  logic                m_icb_areset,
   icb_block_master_if.master  icb
);

   localparam logic [len_width-1:0] LEN_ZERO = len_width'(0);
   localparam logic [len_width-1:0] LEN_ONE  = len_width'(1);

   blk_state_e            r_state;
   blk_state_e            w_state_nxt;
   logic [ICB_ADDR_W-1:0] r_addr;
   logic                  r_read;
   logic [len_width-1:0]  r_cmd_left;
   logic [len_width-1:0]  r_rsp_left;
   logic                  r_err;

   logic w_run;
   logic w_req_hs;
   logic w_cmd_valid;
   logic w_cmd_hs;
   logic w_rsp_ready;
   logic w_rsp_hs;
   logic w_at_limit;

   // Every output is forced quiet while reset is held, even before the state register clears.
   assign w_run       = (r_state == RUN) && !m_icb_areset;
   assign w_req_hs    = icb.blk_req_valid && icb.blk_req_ready;
   assign w_cmd_valid = w_run && (r_cmd_left != LEN_ZERO) && !w_at_limit
                        && (r_read || icb.s_wdata_valid);
   assign w_cmd_hs    = w_cmd_valid && icb.m_icb_cmd_ready;
   assign w_rsp_ready = w_run && (!r_read || icb.m_rdata_ready);
   assign w_rsp_hs    = w_rsp_ready && icb.m_icb_rsp_valid;

   icb_outstanding_cnt #(
      .max_cnt (max_outstanding)
   ) u_outst (
      .i_clk      (m_icb_aclk),
      .i_rst      (m_icb_areset),
      .i_inc      (w_cmd_hs),
      .i_dec      (w_rsp_hs),
      .o_at_limit (w_at_limit)
   );

   // State register.
   always_ff @(posedge m_icb_aclk) begin
      if (m_icb_areset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; an empty block skips straight to DONE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_req_hs) begin
               w_state_nxt = (icb.blk_req_len == LEN_ZERO) ? DONE : RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_rsp_hs && (r_rsp_left == LEN_ONE)) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = RUN;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Block context: address walks by one word per command, counters and error per response.
   always_ff @(posedge m_icb_aclk) begin
      if (m_icb_areset) begin
         r_addr     <= 32'h0000_0000;
         r_read     <= 1'b0;
         r_cmd_left <= LEN_ZERO;
         r_rsp_left <= LEN_ZERO;
         r_err      <= 1'b0;
      end else if (w_req_hs) begin
         r_addr     <= icb.blk_req_addr & 32'hFFFF_FFFC;
         r_read     <= icb.blk_req_read;
         r_cmd_left <= icb.blk_req_len;
         r_rsp_left <= icb.blk_req_len;
         r_err      <= 1'b0;
      end else begin
         if (w_cmd_hs) begin
            r_addr     <= r_addr + 32'd4;
            r_cmd_left <= r_cmd_left - LEN_ONE;
         end
         if (w_rsp_hs) begin
            r_rsp_left <= r_rsp_left - LEN_ONE;
            r_err      <= r_err | icb.m_icb_rsp_err;
         end
      end
   end

   assign icb.blk_req_ready   = (r_state == IDLE) && !m_icb_areset;
   assign icb.blk_done        = (r_state == DONE) && !m_icb_areset;
   assign icb.blk_err         = icb.blk_done && r_err;

   assign icb.s_wdata_ready   = w_cmd_hs && !r_read;
   assign icb.m_rdata         = icb.m_icb_rsp_rdata;
   assign icb.m_rdata_valid   = w_run && r_read && icb.m_icb_rsp_valid;

   assign icb.m_icb_cmd_addr  = r_addr;
   assign icb.m_icb_cmd_read  = r_read;
   assign icb.m_icb_cmd_wdata = icb.s_wdata;
   assign icb.m_icb_cmd_wmask = r_read ? 4'h0 : 4'hF;
   assign icb.m_icb_cmd_valid = w_cmd_valid;
   assign icb.m_icb_rsp_ready = w_rsp_ready;

endmodule

// File: tb/tb_icb_block_master.sv
// Table-driven bench with an ICB slave model and command/read-data scoreboards.
module tb_icb_block_master;
   import icb_pkg::*;

   localparam int MAXO = 2;
   localparam int LW   = 16;
   localparam logic [31:0] DKEY = 32'h5A5A_0000;

   typedef struct { bit rd; logic [31:0] addr; int len; int lat; bit imm; bit gap;
                    int rdy_low; int err_idx; bit exp_err; bit b2b; } vec_t;
   typedef struct { logic [31:0] addr; logic rd; logic [31:0] wd; } cmd_t;
   typedef struct { logic [31:0] data; logic err; int due; } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   icb_block_master_if #(.len_width(LW)) ifc ();

   icb_block_master #(.max_outstanding(MAXO), .len_width(LW)) dut (
      .m_icb_aclk   (clk),
      .m_icb_areset (rst),
      .icb          (ifc.master)
   );

   cmd_t        exp_cmd_q[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] wsrc_q[$];
   rsp_t        sl_q[$];

   int checks = 0, errors = 0;
   bit imm_mode = 1'b0, gap_en = 1'b0, in_blk = 1'b0, blk_rd = 1'b0;
   int lat = 1, err_idx = -1, cmd_idx = 0, unans = 0, rdy_hold = 0;
   int first_cmd_cyc = -1, last_cmd_cyc = -1, last_rsp_cyc = -1;
   logic        sl_valid = 1'b0, sl_err = 1'b0;
   logic [31:0] sl_rdata = 32'h0;

   assign ifc.m_icb_rsp_valid = imm_mode ? (ifc.m_icb_cmd_valid & ifc.m_icb_cmd_ready) : sl_valid;
   assign ifc.m_icb_rsp_rdata = imm_mode ? 32'h0 : sl_rdata;
   assign ifc.m_icb_rsp_err   = imm_mode ? 1'b0 : sl_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Driver: slave response, write-data source and read-sink ready, updated just after each edge.
   initial begin
      ifc.m_icb_cmd_ready = 1'b1;
      ifc.s_wdata_valid   = 1'b0;
      ifc.s_wdata         = 32'h0;
      ifc.m_rdata_ready   = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         sl_valid = !rst && (sl_q.size() > 0) && (sl_q[0].due <= cyc);
         sl_rdata = (sl_q.size() > 0) ? sl_q[0].data : 32'h0;
         sl_err   = (sl_q.size() > 0) ? sl_q[0].err : 1'b0;
         ifc.s_wdata_valid = (wsrc_q.size() > 0) && !(gap_en && (cyc % 3 == 0));
         ifc.s_wdata       = (wsrc_q.size() > 0) ? wsrc_q[0] : 32'h0;
         if (rdy_hold > 0) rdy_hold--;
         ifc.m_rdata_ready = (rdy_hold == 0);
      end
   end

   // Monitor: sample handshakes on the falling edge and score them.
   initial begin
      logic cmd_hs, rsp_hs;
      cmd_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cmd_hs = ifc.m_icb_cmd_valid & ifc.m_icb_cmd_ready;
            rsp_hs = ifc.m_icb_rsp_valid & ifc.m_icb_rsp_ready;
            if (in_blk && !blk_rd) begin
               if (!ifc.s_wdata_valid) chk("cmd_valid_wdata_stall", 64'(ifc.m_icb_cmd_valid), 64'(0));
               chk("s_wdata_ready", 64'(ifc.s_wdata_ready), 64'(cmd_hs));
            end
            if (in_blk && blk_rd && !ifc.m_rdata_ready)
               chk("rsp_ready_backpressure", 64'(ifc.m_icb_rsp_ready), 64'(0));
            if (rsp_hs && !imm_mode && sl_q.size() > 0) void'(sl_q.pop_front());
            if (cmd_hs) begin
               if (exp_cmd_q.size() == 0) begin
                  chk("unexpected_cmd", 64'(1), 64'(0));
               end else begin
                  e = exp_cmd_q.pop_front();
                  chk("cmd_addr", 64'(ifc.m_icb_cmd_addr), 64'(e.addr));
                  chk("cmd_rd_mask_wdata",
                      64'({ifc.m_icb_cmd_read, ifc.m_icb_cmd_wmask, e.rd ? 32'h0 : ifc.m_icb_cmd_wdata}),
                      64'({e.rd, e.rd ? 4'h0 : 4'hF, e.rd ? 32'h0 : e.wd}));
               end
               if (!imm_mode)
                  sl_q.push_back('{data: ifc.m_icb_cmd_addr ^ DKEY, err: (cmd_idx == err_idx), due: cyc + lat});
               if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
               last_cmd_cyc = cyc;
               cmd_idx++;
            end
            unans = unans + int'(cmd_hs) - int'(rsp_hs);
            if (cmd_hs) chk("outstanding_limit", 64'(unans <= (imm_mode ? 0 : MAXO)), 64'(1));
            if (rsp_hs) last_rsp_cyc = cyc;
            if (ifc.m_rdata_valid && ifc.m_rdata_ready) begin
               if (exp_rd_q.size() == 0) chk("unexpected_rdata", 64'(1), 64'(0));
               else chk("rdata", 64'(ifc.m_rdata), 64'(exp_rd_q.pop_front()));
            end
            if (ifc.s_wdata_valid && ifc.s_wdata_ready && wsrc_q.size() > 0) void'(wsrc_q.pop_front());
         end
      end
   end

   // Fill the scoreboards for a block and present the request until it is accepted.
   task automatic start_req(input vec_t v, output int acc, output bit ok);
      logic [31:0] base, a, wd;
      imm_mode = v.imm; gap_en = v.gap; lat = v.lat; err_idx = v.err_idx;
      cmd_idx = 0; first_cmd_cyc = -1; last_rsp_cyc = -1; blk_rd = v.rd;
      base = v.addr & 32'hFFFF_FFFC;
      for (int i = 0; i < v.len; i++) begin
         a  = base + 32'(4 * i);
         wd = $urandom;
         exp_cmd_q.push_back('{addr: a, rd: v.rd, wd: wd});
         if (v.rd) exp_rd_q.push_back(a ^ DKEY);
         else      wsrc_q.push_back(wd);
      end
      rdy_hold = v.rdy_low;
      ifc.blk_req_addr  = v.addr;
      ifc.blk_req_len   = LW'(v.len);
      ifc.blk_req_read  = v.rd;
      ifc.blk_req_valid = 1'b1;
      in_blk = 1'b1;
      ok = 1'b0;
      acc = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (ifc.blk_req_ready) begin ok = 1'b1; acc = cyc; end
      end
      @(posedge clk); #1;
      ifc.blk_req_valid = 1'b0;
      if (!ok) chk("req_accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic run_vec(input vec_t v);
      int acc, done_cyc;
      bit ok, got;
      start_req(v, acc, ok);
      got = 1'b0;
      done_cyc = 0;
      for (int k = 0; k < 500 && ok && !got; k++) begin
         @(negedge clk);
         if (ifc.blk_done) begin got = 1'b1; done_cyc = cyc; end
      end
      if (ok && !got) chk("done_timeout", 64'(0), 64'(1));
      if (got) begin
         chk("blk_err", 64'(ifc.blk_err), 64'(v.exp_err));
         if (v.len == 0) chk("done_latency_empty", 64'(done_cyc), 64'(acc + 1));
         else            chk("done_latency", 64'(done_cyc), 64'(last_rsp_cyc + 1));
         chk("cmd_count", 64'(cmd_idx), 64'(v.len));
         if (v.b2b) chk("b2b_cmds", 64'(last_cmd_cyc - first_cmd_cyc), 64'(v.len - 1));
         chk("queues_drained", 64'(exp_cmd_q.size() + exp_rd_q.size()), 64'(0));
         @(negedge clk);
         chk("done_pulse_width", 64'(ifc.blk_done), 64'(0));
         chk("req_ready_after_done", 64'(ifc.blk_req_ready), 64'(1));
      end
      in_blk = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic clear_sb();
      exp_cmd_q.delete(); exp_rd_q.delete(); wsrc_q.delete(); sl_q.delete();
      unans = 0; in_blk = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      vec_t rv;
      int acc, k;
      bit ok;
      //               rd    addr          len lat imm   gap   rdy err exp   b2b
      vecs[0] = '{1'b1, 32'h0000_0100, 4, 1, 1'b0, 1'b0, 0,  -1, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 32'h0000_0203, 3, 1, 1'b0, 1'b1, 0,  -1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_1000, 5, 1, 1'b1, 1'b0, 0,  -1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'h0000_0300, 6, 6, 1'b0, 1'b0, 12, -1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'h0000_0500, 0, 1, 1'b0, 1'b0, 0,  -1, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 32'h0000_0400, 3, 2, 1'b0, 1'b0, 0,  1,  1'b1, 1'b0};
      vecs[6] = '{1'b0, 32'hFFFF_FFF8, 4, 3, 1'b0, 1'b0, 0,  -1, 1'b0, 1'b0};

      ifc.blk_req_valid = 1'b0;
      ifc.blk_req_addr  = 32'h0;
      ifc.blk_req_len   = 16'h0;
      ifc.blk_req_read  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_cmd_valid", 64'(ifc.m_icb_cmd_valid), 64'(0));
      chk("reset_blk_done", 64'(ifc.blk_done), 64'(0));
      chk("reset_rsp_ready", 64'(ifc.m_icb_rsp_ready), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_req_ready", 64'(ifc.blk_req_ready), 64'(1));
      chk("post_reset_blk_err", 64'(ifc.blk_err), 64'(0));
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset in the middle of an 8-word read while two commands are outstanding.
      rv = '{1'b1, 32'h0000_0800, 8, 30, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0};
      start_req(rv, acc, ok);
      k = 0;
      while (ok && cmd_idx < 2 && k < 20) begin @(negedge clk); k++; end
      chk("two_cmds_before_reset", 64'(cmd_idx), 64'(2));
      repeat (3) @(negedge clk);
      chk("limit_holds_cmds", 64'(cmd_idx), 64'(2));
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_cmd_valid", 64'(ifc.m_icb_cmd_valid), 64'(0));
      chk("midreset_rsp_ready", 64'(ifc.m_icb_rsp_ready), 64'(0));
      chk("midreset_rdata_valid", 64'(ifc.m_rdata_valid), 64'(0));
      chk("midreset_blk_done", 64'(ifc.blk_done), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      clear_sb();
      @(negedge clk);
      chk("after_midreset_req_ready", 64'(ifc.blk_req_ready), 64'(1));
      chk("after_midreset_cmd_valid", 64'(ifc.m_icb_cmd_valid), 64'(0));
      @(posedge clk); #1;
      rv = '{1'b1, 32'h0000_0040, 1, 1, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0};
      run_vec(rv);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
